// File: rtl/me_pkg.sv
// me_pkg: shared constants, FSM encoding, result entry layout.
// ME_SKIP_FLAG_EN adds a per-entry skip bit to the entry.
package me_pkg;

   localparam int MB_PITCH = 16;
   localparam int COORD_W  = 6;
   localparam int SAD_W    = 16;
   localparam int DIFF_W   = 4;
   localparam int IDX_W    = 4;
   localparam int POS_W    = 2 * COORD_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_REQ,
      S_RELEASE,
      S_PUSH
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] mb_idx;
      logic [POS_W-1:0] mvec;
      logic [SAD_W-1:0] sad;
`ifdef ME_SKIP_FLAG_EN
      logic             skip;
`endif
   } res_t;

   localparam int RES_W = $bits(res_t);

endpackage

// File: rtl/me_result_sequencer_if.sv
// me_result_sequencer_if: ME controller handshake plus result stream.
// ME_SKIP_FLAG_EN adds skip_thresh and out_skip.
interface me_result_sequencer_if;
   import me_pkg::*;

   logic               start;
   logic               busy;
   logic               done;
   logic               me_req;
   logic               me_ack;
   logic [POS_W-1:0]   me_init_pos;
   logic [SAD_W-1:0]   me_min_sad;
   logic [DIFF_W-1:0]  me_min_diff;
   logic               out_valid;
   logic               out_ready;
   logic [IDX_W-1:0]   out_mb_idx;
   logic [POS_W-1:0]   out_mvec;
   logic [SAD_W-1:0]   out_sad;
`ifdef ME_SKIP_FLAG_EN
   logic [SAD_W-1:0]   skip_thresh;
   logic               out_skip;
`endif

   modport master (
      input  start,
      input  me_ack,
      input  me_min_sad,
      input  me_min_diff,
      input  out_ready,
`ifdef ME_SKIP_FLAG_EN
      input  skip_thresh,
      output out_skip,
`endif
      output busy,
      output done,
      output me_req,
      output me_init_pos,
      output out_valid,
      output out_mb_idx,
      output out_mvec,
      output out_sad
   );

   modport slave (
      output start,
      output me_ack,
      output me_min_sad,
      output me_min_diff,
      output out_ready,
`ifdef ME_SKIP_FLAG_EN
      output skip_thresh,
      input  out_skip,
`endif
      input  busy,
      input  done,
      input  me_req,
      input  me_init_pos,
      input  out_valid,
      input  out_mb_idx,
      input  out_mvec,
      input  out_sad
   );

endinterface

// File: rtl/me_result_fifo.sv
// me_result_fifo: first-word-fall-through FIFO with occupancy count.
// Push while full is accepted when a pop happens in the same cycle.
module me_result_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop   = i_pop && (r_count != '0);
   assign w_push  = i_push &&
                    ((r_count != CW'(DEPTH)) || w_pop);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rd];

   // storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/me_result_sequencer.sv
// me_result_sequencer: per-MB ME request/ack, vector build, result FIFO.
// ME_SKIP_FLAG_EN adds a SAD-vs-threshold skip flag per result.
module me_result_sequencer
   import me_pkg::*;
#(
   parameter int MB_COLS    = 4,
   parameter int MB_ROWS    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   me_result_sequencer_if.master bus
);

   localparam int CLW = (MB_COLS > 1) ? $clog2(MB_COLS) : 1;
   localparam int RWW = (MB_ROWS > 1) ? $clog2(MB_ROWS) : 1;
   localparam int NMB = MB_COLS * MB_ROWS;
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   localparam int VW  = COORD_W + 2;

   state_t              r_state;
   state_t              w_next;
   logic [CLW-1:0]      r_col;
   logic [RWW-1:0]      r_row;
   logic [IDX_W-1:0]    r_idx;
   logic [POS_W-1:0]    r_pos;
   logic [SAD_W-1:0]    r_sad;
   logic [DIFF_W-1:0]   r_diff;
`ifdef ME_SKIP_FLAG_EN
   logic                r_skip;
`endif

   logic                w_last;
   logic                w_push;
   logic [COORD_W-1:0]  w_x;
   logic [COORD_W-1:0]  w_y;
   logic [VW-1:0]       w_sx;
   logic [VW-1:0]       w_sy;
   logic [COORD_W-1:0]  w_mx;
   logic [COORD_W-1:0]  w_my;
   res_t                w_entry;
   res_t                w_head;
   logic [FCW-1:0]      w_count;
   logic                w_empty;

   assign w_last = (r_idx == IDX_W'(NMB - 1));
   assign w_push = (r_state == S_PUSH);
   assign w_x    = COORD_W'(32'(r_col) * MB_PITCH);
   assign w_y    = COORD_W'(32'(r_row) * MB_PITCH);

   assign bus.me_req      = (r_state == S_REQ);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = w_push && w_last;
   assign bus.me_init_pos = r_pos;

   // signed add of the 2-bit offsets, then clamp to the coordinate range
   assign w_sx = VW'(r_pos[POS_W-1:COORD_W]) +
                 {{COORD_W{r_diff[3]}}, r_diff[3:2]};
   assign w_sy = VW'(r_pos[COORD_W-1:0]) +
                 {{COORD_W{r_diff[1]}}, r_diff[1:0]};
   assign w_mx = w_sx[VW-1] ? '0 :
                 (w_sx[VW-2] ? '1 : w_sx[COORD_W-1:0]);
   assign w_my = w_sy[VW-1] ? '0 :
                 (w_sy[VW-2] ? '1 : w_sy[COORD_W-1:0]);

   // result entry assembled from captured values
   always_comb begin
      w_entry        = '0;
      w_entry.mb_idx = r_idx;
      w_entry.mvec   = {w_mx, w_my};
      w_entry.sad    = r_sad;
`ifdef ME_SKIP_FLAG_EN
      w_entry.skip   = r_skip;
`endif
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (bus.start) w_next = S_CHECK;
         S_CHECK:   if (w_count < FCW'(FIFO_DEPTH))
                       w_next = S_REQ;
         S_REQ:     if (bus.me_ack) w_next = S_RELEASE;
         S_RELEASE: if (!bus.me_ack) w_next = S_PUSH;
         S_PUSH:    w_next = w_last ? S_IDLE : S_CHECK;
         default:   w_next = S_IDLE;
      endcase
   end

   // MB counters, origin register and ME result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_idx  <= '0;
         r_pos  <= '0;
         r_sad  <= '0;
         r_diff <= '0;
`ifdef ME_SKIP_FLAG_EN
         r_skip <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_col <= '0;
            r_row <= '0;
            r_idx <= '0;
         end
         if (r_state == S_CHECK) r_pos <= {w_x, w_y};
         if (r_state == S_REQ && bus.me_ack) begin
            r_sad  <= bus.me_min_sad;
            r_diff <= bus.me_min_diff;
`ifdef ME_SKIP_FLAG_EN
            r_skip <= (bus.me_min_sad <= bus.skip_thresh);
`endif
         end
         if (w_push && !w_last) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_col == CLW'(MB_COLS - 1)) begin
               r_col <= '0;
               r_row <= r_row + RWW'(1);
            end else begin
               r_col <= r_col + CLW'(1);
            end
         end
      end
   end

   me_result_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (bus.out_ready),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign bus.out_valid  = !w_empty;
   assign bus.out_mb_idx = w_head.mb_idx;
   assign bus.out_mvec   = w_head.mvec;
   assign bus.out_sad    = w_head.sad;
`ifdef ME_SKIP_FLAG_EN
   assign bus.out_skip   = w_head.skip;
`endif

endmodule

// File: tb/tb_me_result_sequencer.sv
// tb_me_result_sequencer: directed bench with ME model and consumer.
// ME_SKIP_FLAG_EN enables the skip flag checks.
module tb_me_result_sequencer;
   import me_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   me_result_sequencer_if bus();

   me_result_sequencer #(
      .MB_COLS    (4),
      .MB_ROWS    (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   int lat  = 40;
   int hold = 1;
   logic [15:0] sad_tab [16];
   logic [3:0]  diff_tab [16];
   logic [15:0] exp_sad [16];
   logic [11:0] exp_mv [16];

   logic        rdy_en = 1'b1;
   logic [3:0]  idx_q [$];
   logic [11:0] mv_q [$];
   logic [15:0] sad_q [$];
`ifdef ME_SKIP_FLAG_EN
   logic        skip_q [$];
`endif

   int   done_cnt = 0;
   int   req_rise = 0;
   int   viol     = 0;
   logic p_req    = 1'b0;
   logic p_ack    = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ME controller model: ack after lat cycles, hold after req drops
   initial begin
      int cnt;
      int hc;
      int mi;
      cnt = 0;
      hc  = 0;
      bus.me_ack      = 1'b0;
      bus.me_min_sad  = '0;
      bus.me_min_diff = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.me_ack = 1'b0;
            cnt = 0;
         end else if (!bus.me_ack) begin
            if (bus.me_req) begin
               cnt++;
               if (cnt >= lat) begin
                  mi = int'(bus.me_init_pos[11:10]) +
                       4 * int'(bus.me_init_pos[5:4]);
                  bus.me_min_sad  = sad_tab[mi];
                  bus.me_min_diff = diff_tab[mi];
                  bus.me_ack = 1'b1;
                  cnt = 0;
                  hc  = 0;
               end
            end else begin
               cnt = 0;
            end
         end else if (!bus.me_req) begin
            hc++;
            if (hc >= hold) bus.me_ack = 1'b0;
         end
      end
   end

   // consumer: drive ready, record every popped entry
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.out_ready = rdy_en;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            idx_q.push_back(bus.out_mb_idx);
            mv_q.push_back(bus.out_mvec);
            sad_q.push_back(bus.out_sad);
`ifdef ME_SKIP_FLAG_EN
            skip_q.push_back(bus.out_skip);
`endif
         end
      end
   end

   // monitor: done pulses, req rises, req-while-ack violations
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (bus.done) done_cnt++;
         if (bus.me_req && !p_req) begin
            req_rise++;
            if (bus.me_ack || p_ack) viol++;
         end
         p_req = bus.me_req;
         p_ack = bus.me_ack;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done_cnt != d0), 1);
   endtask

   task automatic clear_q();
      idx_q.delete();
      mv_q.delete();
      sad_q.delete();
`ifdef ME_SKIP_FLAG_EN
      skip_q.delete();
`endif
   endtask

   task automatic chk_frame(input string tag, input int n);
      chk({tag, "_n"}, idx_q.size(), n);
      for (int i = 0; i < n && i < idx_q.size(); i++) begin
         chk($sformatf("%s_idx%0d", tag, i), idx_q[i], i);
         chk($sformatf("%s_mv%0d", tag, i), mv_q[i], exp_mv[i]);
         chk($sformatf("%s_sad%0d", tag, i), sad_q[i], exp_sad[i]);
      end
   endtask

   task automatic set_base(input logic [15:0] s0, input int inc);
      for (int i = 0; i < 16; i++) begin
         sad_tab[i]  = s0 + 16'(i * inc);
         exp_sad[i]  = s0 + 16'(i * inc);
         diff_tab[i] = 4'b0000;
         exp_mv[i]   = {6'(16 * (i % 4)), 6'(16 * (i / 4))};
      end
   endtask

   initial begin
      int d0;
      int r0;
      int v0;
      int n;
      bus.start = 1'b0;
`ifdef ME_SKIP_FLAG_EN
      bus.skip_thresh = 16'h0100;
`endif
      set_base(16'h0123, 0);
      diff_tab[0]  = 4'b1010;
      exp_mv[0]    = 12'h000;
      diff_tab[5]  = 4'b0101;
      exp_mv[5]    = {6'd17, 6'd17};
      diff_tab[15] = 4'b0101;
      exp_mv[15]   = {6'd49, 6'd49};

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_req", bus.me_req, 0);
      chk("rst_pos", bus.me_init_pos, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_idx", bus.out_mb_idx, 0);
      chk("rst_mvec", bus.out_mvec, 0);
      chk("rst_sad", bus.out_sad, 0);
      rst_n = 1'b1;
      @(negedge clk);

      d0 = done_cnt;
      pulse_start();
      chk("t1_busy_c1", bus.busy, 1);
      chk("t1_req_c1", bus.me_req, 0);
      @(negedge clk);
      chk("t1_req_c2", bus.me_req, 1);
      chk("t1_pos_c2", bus.me_init_pos, 0);
      repeat (100) @(negedge clk);
      pulse_start();
      wait_done("t1_done", 3000);
      repeat (4) @(negedge clk);
      chk("t1_done_cnt", done_cnt - d0, 1);
      chk("t1_busy_end", bus.busy, 0);
      chk("t1_valid_end", bus.out_valid, 0);
      chk_frame("t1", 16);

      clear_q();
      lat = 3;
      set_base(16'h0200, 1);
      rdy_en = 1'b0;
      r0 = req_rise;
      @(negedge clk);
      pulse_start();
      repeat (200) @(negedge clk);
      chk("t2_reqs", req_rise - r0, 4);
      chk("t2_req_low", bus.me_req, 0);
      chk("t2_busy", bus.busy, 1);
      chk("t2_valid", bus.out_valid, 1);
      chk("t2_head_idx", bus.out_mb_idx, 0);
      chk("t2_head_sad", bus.out_sad, 16'h0200);
      chk("t2_popped", idx_q.size(), 0);
      @(posedge clk);
      #1 rdy_en = 1'b1;
      @(posedge clk);
      #1 rdy_en = 1'b0;
      repeat (40) @(negedge clk);
      chk("t2_reqs_one", req_rise - r0, 5);
      chk("t2_popped_one", idx_q.size(), 1);
      chk("t2_head_idx1", bus.out_mb_idx, 1);
      rdy_en = 1'b1;
      wait_done("t2_done", 2000);
      repeat (4) @(negedge clk);
      chk_frame("t2", 16);

      clear_q();
      lat  = 2;
      hold = 5;
      v0 = viol;
      r0 = req_rise;
      pulse_start();
      wait_done("t3_done", 2000);
      repeat (4) @(negedge clk);
      chk("t3_viol", viol - v0, 0);
      chk("t3_reqs", req_rise - r0, 16);
      chk_frame("t3", 16);

      clear_q();
      lat  = 3;
      hold = 1;
      pulse_start();
      n = 0;
      while (!(bus.me_req &&
               bus.me_init_pos == {6'd48, 6'd16}) &&
             n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("t4_mb7_req", 32'(n < 1000), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t4_rst_req", bus.me_req, 0);
      chk("t4_rst_valid", bus.out_valid, 0);
      chk("t4_rst_busy", bus.busy, 0);
      chk("t4_rst_done", bus.done, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      clear_q();
      chk("t4_idle_valid", bus.out_valid, 0);
      sad_tab[0] = 16'h0100;
      exp_sad[0] = 16'h0100;
      sad_tab[1] = 16'h0101;
      exp_sad[1] = 16'h0101;
      pulse_start();
      wait_done("t4_done", 2000);
      repeat (4) @(negedge clk);
      chk_frame("t4", 16);
`ifdef ME_SKIP_FLAG_EN
      if (skip_q.size() >= 3) begin
         chk("skip_eq", skip_q[0], 1);
         chk("skip_gt", skip_q[1], 0);
         chk("skip_mb2", skip_q[2], 0);
      end else begin
         chk("skip_n", skip_q.size(), 16);
      end
`endif
      chk("viol_total", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/me_result_sequencer.md
Name: me_result_sequencer

Overview:
- Frame-level sequencer directly upstream/downstream of the integer-pel ME controller.
- Per macroblock it drives init_pos and req to the controller, waits for ack, captures min_sad/min_diff, and releases req.
- It forms the absolute motion vector from init_pos plus the decoded offset and pushes {mb_idx, mvec, sad} into an output FIFO drained by a valid/ready consumer.

Parameters:
- MB_COLS, 4, macroblocks per row (MB pitch 16 px, 6-bit coordinate space).
- MB_ROWS, 4, macroblock rows per frame.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle frame start pulse; ignored while busy=1.
- busy  out  1  high from accepted start until last MB result is pushed.
- done  out  1  one-cycle pulse in the cycle the last MB result is pushed.
- me_req  out  1  request to ME controller.
- me_ack  in  1  ack from ME controller.
- me_init_pos  out  12  {x[11:6], y[5:0]} of current MB origin.
- me_min_sad  in  16  SAD from ME controller; valid while me_ack=1.
- me_min_diff  in  4  {dx[3:2], dy[1:0]}, 2-bit two's complement each (-2..+1); valid while me_ack=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept; pop when out_valid&&out_ready.
- out_mb_idx  out  4  raster MB index (row*MB_COLS+col).
- out_mvec  out  12  {mx[11:6], my[5:0]} absolute vector.
- out_sad  out  16  captured SAD.

Behaviour:
- Reset values: busy=0, done=0, me_req=0, me_init_pos=0, out_valid=0, out_* data=0, FIFO emptied, MB counters=0, FSM=IDLE.
- me_init_pos = {col*16, row*16}, registered, stable from REQ entry until RELEASE exit.
- FSM states:
  - IDLE: on start -> CHECK; set busy=1; clear col/row.
  - CHECK: if FIFO count < FIFO_DEPTH -> REQ, else stay (backpressure stall, me_req=0).
  - REQ: me_req=1; when me_ack=1, capture me_min_sad/me_min_diff, drop me_req the next cycle -> RELEASE.
  - RELEASE: me_req=0; wait me_ack=0 -> PUSH.
  - PUSH: write one FIFO entry (space guaranteed by CHECK).
    - If last MB: done=1, busy=0 -> IDLE.
    - Otherwise advance col (wrap to 0, row+1) -> CHECK.
- me_req never reasserts in the same cycle me_ack is observed low. At least one cycle of me_req=0 with me_ack=0 separates requests.
- Vector arithmetic (8-bit signed intermediate):
  - mx = clamp(x + sext(dx), 0, 63).
  - my = clamp(y + sext(dy), 0, 63).
- FIFO: first-word-fall-through. out_* reflect head entry combinationally from registered storage.
  - Simultaneous push and pop permitted at any count, including full.
  - Pop on empty is ignored.
- Results of a frame stay in the FIFO after done; a new start may be accepted while the FIFO still holds entries.
- start during busy: ignored, no effect on counters.
- Reset mid-operation: all state cleared immediately, me_req=0, in-flight MB discarded.
- Latency, start -> me_req: 2 cycles (IDLE->CHECK->REQ) when the FIFO is not full.

Optional Feature:
- ME_SKIP_FLAG_EN defined:
  - Adds input skip_thresh[15:0] and output out_skip[1].
  - out_skip=1 iff captured SAD <= skip_thresh; stored per FIFO entry.
  - skip_thresh is sampled at capture.
- Not defined: those ports and the FIFO bit do not exist; behaviour otherwise identical.

Decomposition:
- Shared package me_pkg:
  - MB_PITCH=16, COORD_W=6, SAD_W=16, DIFF_W=4.
  - FSM state encoding.
  - Result-entry struct/width constant {mb_idx, mvec, sad[, skip]}.
- Sub-module me_result_fifo: parameterised width/depth FWFT FIFO with count output.
- Clamp/add logic stays inline.

Test Plan:
- Reset, then start; the model controller acks after 40 cycles with sad=0x0123, diff=4'b0000 for all MBs.
  - Required: 16 entries, idx 0..15, mvec {col*16,row*16}, sad 0x0123.
  - Single done pulse; busy low after it.
- MB0 diff=4'b1010 (dx=-2, dy=-2) -> mvec {0,0} (clamp).
- MB5 diff=4'b0101 (dx=+1, dy=+1) -> mvec {17,17}.
- MB15 diff=4'b0101 -> mvec {49,49}.
- Hold out_ready=0: after 4 entries me_req stays 0 in CHECK.
  - Release out_ready: exactly one new req per freed slot; entries are not lost or reordered.
- Handshake check: me_ack held high 5 cycles after me_req falls -> no new me_req until 1 cycle after me_ack=0.
  - start pulsed while busy -> ignored.
- Assert rst_n=0 during REQ of MB7: me_req=0, out_valid=0, busy=0 immediately.
  - A new start restarts at idx 0.
- With ME_SKIP_FLAG_EN and skip_thresh=0x0100: sad=0x0100 -> out_skip=1; sad=0x0101 -> out_skip=0.
